// File: rtl/useq_ctrl_sequencer.sv
// Microprogram sequencer: steps an external microcode ROM one word per cycle, with
// conditional branches, a return stack, instruction fetch handshake, stall, halt and error freeze.
module useq_ctrl_sequencer #(
    parameter int INSTR_W     = 8,
    parameter int UADDR_W     = 8,
    parameter int CTRL_W      = 28,
    parameter int OPC_LSB     = 0,
    parameter int OPC_W       = 3,
    parameter int DEC_BASE    = 16,
    parameter int DEC_SHIFT   = 2,
    parameter int N_COND      = 4,
    parameter int COND_SEL_W  = 2,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_ADDR  = 0
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [INSTR_W-1:0]                          instr_i,
    input  logic                                        instr_valid_i,
    output logic                                        instr_ready_o,
    input  logic [N_COND-1:0]                           cond_i,
    input  logic                                        stall_i,
    output logic [UADDR_W-1:0]                          uaddr_o,
    input  logic [CTRL_W+3+1+COND_SEL_W+UADDR_W-1:0]    uword_i,
    output logic [CTRL_W-1:0]                           ctrl_o,
    output logic [INSTR_W-1:0]                          ir_o,
    output logic                                        eoi_o,
    output logic                                        halted_o,
    output logic                                        err_o
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [2:0] {
        OP_NEXT   = 3'd0,
        OP_JUMP   = 3'd1,
        OP_COND   = 3'd2,
        OP_CALL   = 3'd3,
        OP_RET    = 3'd4,
        OP_DECODE = 3'd5,
        OP_FETCH  = 3'd6,
        OP_HALT   = 3'd7
    } op_e;

    logic [UADDR_W-1:0]    upc_q, upc_d;
    logic [SP_W-1:0]       sp_q, sp_d;
    logic [INSTR_W-1:0]    ir_q, ir_d;
    logic                  halted_q, halted_d;
    logic                  err_q, err_d;
    logic [UADDR_W-1:0]    stack_q [STACK_DEPTH];

    logic [CTRL_W-1:0]     w_ctrl;
    op_e                   w_op;
    logic                  w_inv;
    logic [COND_SEL_W-1:0] w_csel;
    logic [UADDR_W-1:0]    w_target;

    logic [UADDR_W-1:0]    upc_inc;
    logic [IDX_W-1:0]      push_idx, pop_idx;
    logic [OPC_W-1:0]      opc;
    logic                  cond_bit;
    logic                  active;
    logic                  push_en;
    logic                  ready_c, eoi_c;
    logic [CTRL_W-1:0]     ctrl_c;

    assign w_ctrl   = uword_i[CTRL_W-1:0];
    assign w_op     = op_e'(uword_i[CTRL_W +: 3]);
    assign w_inv    = uword_i[CTRL_W+3];
    assign w_csel   = uword_i[CTRL_W+4 +: COND_SEL_W];
    assign w_target = uword_i[CTRL_W+4+COND_SEL_W +: UADDR_W];

    assign upc_inc  = upc_q + UADDR_W'(1);
    assign push_idx = IDX_W'(sp_q);
    assign pop_idx  = IDX_W'(sp_q - SP_W'(1));
    assign opc      = ir_q[OPC_LSB +: OPC_W];
    // Stall, halt and a stack error all freeze the sequencer identically.
    assign active   = rst_n && !stall_i && !halted_q && !err_q;

    // Selects beyond the implemented condition inputs read as 0.
    always_comb begin
        cond_bit = 1'b0;
        for (int i = 0; i < N_COND; i++) begin
            if (w_csel == COND_SEL_W'(i)) cond_bit = cond_i[i];
        end
    end

    always_comb begin
        upc_d    = upc_q;
        sp_d     = sp_q;
        ir_d     = ir_q;
        halted_d = halted_q;
        err_d    = err_q;
        push_en  = 1'b0;
        ready_c  = 1'b0;
        eoi_c    = 1'b0;
        ctrl_c   = '0;
        if (active) begin
            ctrl_c = w_ctrl;
            unique case (w_op)
                OP_NEXT: upc_d = upc_inc;
                OP_JUMP: upc_d = w_target;
                OP_COND: upc_d = (cond_bit ^ w_inv) ? w_target : upc_inc;
                OP_CALL: begin
                    if (sp_q == SP_W'(STACK_DEPTH)) begin
                        err_d = 1'b1;
                    end else begin
                        push_en = 1'b1;
                        sp_d    = sp_q + SP_W'(1);
                        upc_d   = w_target;
                    end
                end
                OP_RET: begin
                    if (sp_q == '0) begin
                        err_d = 1'b1;
                        upc_d = UADDR_W'(RESET_ADDR);
                    end else begin
                        sp_d  = sp_q - SP_W'(1);
                        upc_d = stack_q[pop_idx];
                    end
                end
                OP_DECODE: upc_d = UADDR_W'(DEC_BASE) + UADDR_W'(32'(opc) << DEC_SHIFT);
                OP_FETCH: begin
                    ready_c = 1'b1;
                    if (instr_valid_i) begin
                        eoi_c = 1'b1;
                        ir_d  = instr_i;
                        upc_d = w_target;
                    end
                end
                OP_HALT: halted_d = 1'b1;
                default: upc_d = upc_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upc_q    <= UADDR_W'(RESET_ADDR);
            sp_q     <= '0;
            ir_q     <= '0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
        end else begin
            upc_q    <= upc_d;
            sp_q     <= sp_d;
            ir_q     <= ir_d;
            halted_q <= halted_d;
            err_q    <= err_d;
            if (push_en) stack_q[push_idx] <= upc_inc;
        end
    end

    assign uaddr_o       = upc_q;
    assign ctrl_o        = ctrl_c;
    assign instr_ready_o = ready_c;
    assign eoi_o         = eoi_c;
    assign ir_o          = ir_q;
    assign halted_o      = halted_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_useq_ctrl_sequencer.sv
// Directed bench for useq_ctrl_sequencer: bench-owned microcode ROM, a queue-based
// reference model checked every cycle, plus hand-computed literal expectations.
module tb_useq_ctrl_sequencer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  instr;
    logic        valid;
    logic [3:0]  cond;
    logic        stall;
    logic        ready_o, eoi_o, halted_o, err_o;
    logic [7:0]  uaddr_o, ir_o;
    logic [27:0] ctrl_o;
    logic [41:0] uword;
    logic [41:0] rom [256];

    int n_chk  = 0;
    int n_fail = 0;

    useq_ctrl_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_i       (instr),
        .instr_valid_i (valid),
        .instr_ready_o (ready_o),
        .cond_i        (cond),
        .stall_i       (stall),
        .uaddr_o       (uaddr_o),
        .uword_i       (uword),
        .ctrl_o        (ctrl_o),
        .ir_o          (ir_o),
        .eoi_o         (eoi_o),
        .halted_o      (halted_o),
        .err_o         (err_o)
    );

    assign uword = rom[uaddr_o];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [41:0] mk(int op, int tgt, int csel, int inv, logic [27:0] c);
        return {8'(tgt), 2'(csel), 1'(inv), 3'(op), c};
    endfunction

    function automatic int f_op(logic [7:0] a);
        return int'(rom[a][30:28]);
    endfunction
    function automatic logic [7:0] f_tgt(logic [7:0] a);
        return rom[a][41:34];
    endfunction
    function automatic int f_csel(logic [7:0] a);
        return int'(rom[a][33:32]);
    endfunction
    function automatic int f_inv(logic [7:0] a);
        return int'(rom[a][31]);
    endfunction

    // Reference model: program counter, return stack as a queue, instruction register, flags.
    logic [7:0] m_upc, m_ir;
    logic       m_halt, m_err;
    logic [7:0] m_stk [$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_upc  <= 8'd0;
            m_ir   <= 8'd0;
            m_halt <= 1'b0;
            m_err  <= 1'b0;
            m_stk.delete();
        end else if (!stall && !m_halt && !m_err) begin
            case (f_op(m_upc))
                0: m_upc <= 8'((int'(m_upc) + 1) % 256);
                1: m_upc <= f_tgt(m_upc);
                2: m_upc <= ((((int'(cond) >> f_csel(m_upc)) & 1) ^ f_inv(m_upc)) != 0)
                            ? f_tgt(m_upc) : 8'((int'(m_upc) + 1) % 256);
                3: begin
                    if (m_stk.size() >= 4) m_err <= 1'b1;
                    else begin
                        m_stk.push_back(8'((int'(m_upc) + 1) % 256));
                        m_upc <= f_tgt(m_upc);
                    end
                end
                4: begin
                    if (m_stk.size() == 0) begin
                        m_err <= 1'b1;
                        m_upc <= 8'd0;
                    end else m_upc <= m_stk.pop_back();
                end
                5: m_upc <= 8'((16 + 4 * (int'(m_ir) % 8)) % 256);
                6: if (valid) begin
                    m_ir  <= instr;
                    m_upc <= f_tgt(m_upc);
                end
                default: m_halt <= 1'b1;
            endcase
        end
    end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare();
        logic        act;
        logic [27:0] e_ctrl;
        logic        e_rdy;
        act    = rst_n && !stall && !m_halt && !m_err;
        e_ctrl = act ? rom[m_upc][27:0] : 28'd0;
        e_rdy  = act && (f_op(m_upc) == 6);
        chk("uaddr", 64'(uaddr_o), 64'(m_upc));
        chk("ctrl", 64'(ctrl_o), 64'(e_ctrl));
        chk("ready", 64'(ready_o), 64'(e_rdy));
        chk("eoi", 64'(eoi_o), 64'(e_rdy && valid));
        chk("ir", 64'(ir_o), 64'(m_ir));
        chk("halted", 64'(halted_o), 64'(m_halt));
        chk("err", 64'(err_o), 64'(m_err));
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = mk(0, 0, 0, 0, 28'(i * 7 + 3));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        valid = 1'b0;
        instr = 8'h00;
        cond  = 4'h0;
        #3;
        chk("rst_uaddr", 64'(uaddr_o), 64'd0);
        chk("rst_ctrl", 64'(ctrl_o), 64'd0);
        chk("rst_ready", 64'(ready_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_halted", 64'(halted_o), 64'd0);
        chk("rst_ir", 64'(ir_o), 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        valid = 1'b0;
        instr = 8'h00;
        cond  = 4'h0;
        clear_rom();

        // Sequential stepping and address wrap
        do_reset();
        #1 chk("ctrl_first", 64'(ctrl_o), 64'd3);
        for (int i = 0; i < 255; i++) tick();
        chk("wrap_pre", 64'(uaddr_o), 64'd255);
        tick();
        chk("wrap", 64'(uaddr_o), 64'd0);

        // Fetch handshake with delayed valid
        clear_rom();
        rom[0] = mk(6, 5, 0, 0, 28'h0000111);
        do_reset();
        for (int i = 0; i < 3; i++) tick();
        chk("fetch_hold", 64'(uaddr_o), 64'd0);
        chk("fetch_noeoi", 64'(eoi_o), 64'd0);
        valid = 1'b1;
        instr = 8'hA3;
        #1;
        chk("fetch_eoi", 64'(eoi_o), 64'd1);
        chk("fetch_ready", 64'(ready_o), 64'd1);
        tick();
        valid = 1'b0;
        #1;
        chk("fetch_ir", 64'(ir_o), 64'hA3);
        chk("fetch_upc", 64'(uaddr_o), 64'd5);
        chk("fetch_eoi_end", 64'(eoi_o), 64'd0);

        // Decode dispatch and conditional branches
        clear_rom();
        rom[0]  = mk(6, 1, 0, 0, 28'h0000222);
        rom[1]  = mk(5, 0, 0, 0, 28'h0000333);
        rom[40] = mk(2, 60, 1, 0, 28'h0000444);
        rom[60] = mk(1, 40, 0, 0, 28'h0000555);
        rom[41] = mk(2, 70, 3, 1, 28'h0000666);
        do_reset();
        valid = 1'b1;
        instr = 8'h06;
        tick();
        valid = 1'b0;
        tick();
        chk("decode", 64'(uaddr_o), 64'd40);
        cond = 4'b0010;
        tick();
        chk("cond_taken", 64'(uaddr_o), 64'd60);
        tick();
        cond = 4'b0000;
        tick();
        chk("cond_fall", 64'(uaddr_o), 64'd41);
        cond = 4'b0111;
        tick();
        chk("cond_inv", 64'(uaddr_o), 64'd70);

        // Stack overflow on the fifth nested call
        clear_rom();
        rom[0]  = mk(3, 10, 0, 0, 28'h0000010);
        rom[10] = mk(3, 20, 0, 0, 28'h0000020);
        rom[20] = mk(3, 30, 0, 0, 28'h0000030);
        rom[30] = mk(3, 40, 0, 0, 28'h0000040);
        rom[40] = mk(3, 50, 0, 0, 28'h0000050);
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        chk("call4_upc", 64'(uaddr_o), 64'd40);
        chk("call4_err", 64'(err_o), 64'd0);
        tick();
        chk("ovf_err", 64'(err_o), 64'd1);
        chk("ovf_upc", 64'(uaddr_o), 64'd40);
        chk("ovf_ctrl", 64'(ctrl_o), 64'd0);
        tick();
        tick();

        // Return on an empty stack
        clear_rom();
        rom[0] = mk(1, 7, 0, 0, 28'h0000077);
        rom[7] = mk(4, 0, 0, 0, 28'h0000088);
        do_reset();
        tick();
        chk("ret_pre", 64'(uaddr_o), 64'd7);
        tick();
        chk("unf_err", 64'(err_o), 64'd1);
        chk("unf_upc", 64'(uaddr_o), 64'd0);
        tick();

        // Stall mid-call, fetch under stall, halt, async reset
        clear_rom();
        rom[0]  = mk(3, 10, 0, 0, 28'h0000101);
        rom[10] = mk(3, 20, 0, 0, 28'h0000202);
        rom[20] = mk(4, 0, 0, 0, 28'h0000303);
        rom[11] = mk(4, 0, 0, 0, 28'h0000404);
        rom[1]  = mk(6, 3, 0, 0, 28'h0000505);
        rom[3]  = mk(7, 0, 0, 0, 28'hABCDEF0);
        do_reset();
        tick();
        stall = 1'b1;
        #1 chk("stall_ctrl", 64'(ctrl_o), 64'd0);
        tick();
        tick();
        chk("stall_upc", 64'(uaddr_o), 64'd10);
        stall = 1'b0;
        tick();
        chk("resume_upc", 64'(uaddr_o), 64'd20);
        tick();
        chk("ret1", 64'(uaddr_o), 64'd11);
        tick();
        chk("ret2", 64'(uaddr_o), 64'd1);
        stall = 1'b1;
        valid = 1'b1;
        instr = 8'h5C;
        #1;
        chk("stall_ready", 64'(ready_o), 64'd0);
        chk("stall_eoi", 64'(eoi_o), 64'd0);
        tick();
        chk("stall_fetch_upc", 64'(uaddr_o), 64'd1);
        chk("stall_fetch_ir", 64'(ir_o), 64'd0);
        stall = 1'b0;
        #1 chk("unstall_eoi", 64'(eoi_o), 64'd1);
        tick();
        valid = 1'b0;
        chk("fetch2_ir", 64'(ir_o), 64'h5C);
        #1 chk("halt_word_ctrl", 64'(ctrl_o), 64'hABCDEF0);
        tick();
        chk("halted", 64'(halted_o), 64'd1);
        chk("halt_upc", 64'(uaddr_o), 64'd3);
        chk("halt_ctrl", 64'(ctrl_o), 64'd0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("async_upc", 64'(uaddr_o), 64'd0);
        chk("async_halted", 64'(halted_o), 64'd0);
        chk("async_ir", 64'(ir_o), 64'd0);
        chk("async_ctrl", 64'(ctrl_o), 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
